predictor_flush_controller: RTL and testbench

- Sequences the branch-prediction path of the core: holds a direct-mapped table of 2-bit saturating counters and issues a taken/not-taken prediction plus next-fetch address for each fetched branch.
- Consumes the per-branch resolution produced by the prediction-check stage: successful flag, actual result, failback address.
- On a mispredict, drives a one-cycle PC redirect and a timed pipeline flush/stall sequence.
- Sits between the fetch stage and the execute-stage prediction check.

---
 rtl/predictor_flush_controller_pkg.sv | 13 +
 rtl/predictor_counter_table.sv | 36 +++
 rtl/predictor_flush_controller.sv | 111 +++++++++++
 tb/tb_predictor_flush_controller.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/predictor_flush_controller_pkg.sv
// predictor_flush_controller_pkg: shared widths, counter encodings and FSM states
package predictor_flush_controller_pkg;

    localparam int ADDR_W_DEF = 11;

    localparam logic [1:0] STRONG_NT = 2'b00;
    localparam logic [1:0] WEAK_NT   = 2'b01;
    localparam logic [1:0] WEAK_T    = 2'b10;
    localparam logic [1:0] STRONG_T  = 2'b11;

    typedef enum logic {RUN, FLUSH} state_t;

endpackage

// File: rtl/predictor_counter_table.sv
// predictor_counter_table: direct-mapped table of 2-bit saturating branch counters
// Ports: clk, rst_n (async, active low, all counters -> WEAK_NT);
//        rd_idx/rd_ctr combinational lookup; wr_en/wr_idx/wr_taken saturating update.
module predictor_counter_table
    import predictor_flush_controller_pkg::*;
#(
    parameter int TABLE_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [TABLE_BITS-1:0] rd_idx,
    output logic [1:0]            rd_ctr,
    input  logic                  wr_en,
    input  logic [TABLE_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int N = 1 << TABLE_BITS;

    logic [1:0] ctr [N];
    logic [1:0] cur;

    assign cur    = ctr[wr_idx];
    // Lookup reads the pre-update value; a same-cycle write lands at the edge.
    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) ctr[i] <= WEAK_NT;
        end else if (wr_en) begin
            ctr[wr_idx] <= wr_taken ? (cur == STRONG_T ? STRONG_T : cur + 2'd1)
                                    : (cur == STRONG_NT ? STRONG_NT : cur - 2'd1);
        end
    end

endmodule

// File: rtl/predictor_flush_controller.sv
// predictor_flush_controller: branch prediction plus mispredict redirect/flush sequencing
// Ports: clk, rst_n (async, active low); fetch_* in -> predict_taken/predict_addr (registered);
//        resolve_* / failback_addr in -> redirect_valid/redirect_addr, flush, stall.
// Optional: define PREDICTOR_STATS_EN to add saturating 16-bit hit_count/miss_count outputs.
module predictor_flush_controller
    import predictor_flush_controller_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int TABLE_BITS   = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_valid,
    input  logic              fetch_is_branch,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [ADDR_W-1:0] fetch_target,
    output logic              predict_taken,
    output logic [ADDR_W-1:0] predict_addr,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_addr,
    input  logic              resolve_result,
    input  logic              resolve_successful,
    input  logic [ADDR_W-1:0] failback_addr,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              flush,
    output logic              stall
`ifdef PREDICTOR_STATS_EN
    ,
    output logic [15:0]       hit_count,
    output logic [15:0]       miss_count
`endif
);

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [1:0] rd_ctr;
    logic       in_run, mispredict, guess_taken;

    assign in_run      = state == RUN;
    assign mispredict  = in_run & resolve_valid & ~resolve_successful;
    assign guess_taken = fetch_is_branch & rd_ctr[1];

    // Resolves arriving during FLUSH belong to squashed instructions.
    predictor_counter_table #(.TABLE_BITS(TABLE_BITS)) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (fetch_addr[TABLE_BITS-1:0]),
        .rd_ctr   (rd_ctr),
        .wr_en    (in_run & resolve_valid),
        .wr_idx   (resolve_addr[TABLE_BITS-1:0]),
        .wr_taken (resolve_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Down-counter loads FLUSH_CYCLES-1 so flush/stall are high exactly FLUSH_CYCLES cycles.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flush     = state == FLUSH;
        stall     = state == FLUSH;
        if (in_run) begin
            state_nxt = mispredict ? FLUSH : RUN;
            cnt_nxt   = mispredict ? 4'(FLUSH_CYCLES - 1) : cnt;
        end else begin
            state_nxt = cnt == 4'd0 ? RUN : FLUSH;
            cnt_nxt   = cnt == 4'd0 ? cnt : cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            predict_taken  <= 1'b0;
            predict_addr   <= '0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_addr <= failback_addr;
            if (!in_run) begin
                predict_taken <= 1'b0;
            end else if (fetch_valid) begin
                predict_taken <= guess_taken;
                predict_addr  <= guess_taken ? fetch_target : fetch_addr + 1'b1;
            end
        end
    end

`ifdef PREDICTOR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (in_run & resolve_valid) begin
            if (resolve_successful) hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
            else miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
        end
    end
`endif

endmodule

// File: tb/tb_predictor_flush_controller.sv
// tb_predictor_flush_controller: directed and randomized checks against a behavioural model
module tb_predictor_flush_controller;

    localparam int AW = 11;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fetch_valid = 1'b0, fetch_is_branch = 1'b0;
    logic [AW-1:0] fetch_addr = '0, fetch_target = '0;
    logic          predict_taken;
    logic [AW-1:0] predict_addr;
    logic          resolve_valid = 1'b0, resolve_result = 1'b0, resolve_successful = 1'b0;
    logic [AW-1:0] resolve_addr = '0, failback_addr = '0;
    logic          redirect_valid;
    logic [AW-1:0] redirect_addr;
    logic          flush, stall;
`ifdef PREDICTOR_STATS_EN
    logic [15:0]   hit_count, miss_count;
`endif

    predictor_flush_controller #(.ADDR_W(AW), .TABLE_BITS(4), .FLUSH_CYCLES(FC)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .fetch_valid        (fetch_valid),
        .fetch_is_branch    (fetch_is_branch),
        .fetch_addr         (fetch_addr),
        .fetch_target       (fetch_target),
        .predict_taken      (predict_taken),
        .predict_addr       (predict_addr),
        .resolve_valid      (resolve_valid),
        .resolve_addr       (resolve_addr),
        .resolve_result     (resolve_result),
        .resolve_successful (resolve_successful),
        .failback_addr      (failback_addr),
        .redirect_valid     (redirect_valid),
        .redirect_addr      (redirect_addr),
        .flush              (flush),
        .stall              (stall)
`ifdef PREDICTOR_STATS_EN
        ,
        .hit_count          (hit_count),
        .miss_count         (miss_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: counters as integers 0..3, flush_left = remaining flush cycles.
    int            mc [16];
    int            flush_left;
    logic          m_pt, m_rv;
    logic [AW-1:0] m_pa, m_ra;
    int            m_hits, m_miss;
    int            total = 0, bad = 0;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mc[i] = 1;
        flush_left = 0;
        m_pt = 0; m_rv = 0; m_pa = '0; m_ra = '0;
        m_hits = 0; m_miss = 0;
    endtask

    task automatic model_edge();
        int i;
        if (flush_left == 0) begin
            if (fetch_valid) begin
                m_pt = fetch_is_branch && mc[int'(fetch_addr) % 16] >= 2;
                m_pa = m_pt ? fetch_target : AW'((int'(fetch_addr) + 1) % 2048);
            end
            m_rv = 0;
            if (resolve_valid) begin
                i = int'(resolve_addr) % 16;
                mc[i] = resolve_result ? (mc[i] == 3 ? 3 : mc[i] + 1) : (mc[i] == 0 ? 0 : mc[i] - 1);
                if (resolve_successful) m_hits = m_hits < 65535 ? m_hits + 1 : m_hits;
                else begin
                    m_miss = m_miss < 65535 ? m_miss + 1 : m_miss;
                    m_rv = 1;
                    m_ra = failback_addr;
                    flush_left = FC;
                end
            end
        end else begin
            m_pt = 0;
            m_rv = 0;
            flush_left--;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".predict_taken"}, 16'(predict_taken), 16'(m_pt));
        chk({tag, ".predict_addr"}, 16'(predict_addr), 16'(m_pa));
        chk({tag, ".redirect_valid"}, 16'(redirect_valid), 16'(m_rv));
        chk({tag, ".redirect_addr"}, 16'(redirect_addr), 16'(m_ra));
        chk({tag, ".flush"}, 16'(flush), 16'(flush_left > 0));
        chk({tag, ".stall"}, 16'(stall), 16'(flush_left > 0));
`ifdef PREDICTOR_STATS_EN
        chk({tag, ".hit_count"}, hit_count, 16'(m_hits));
        chk({tag, ".miss_count"}, miss_count, 16'(m_miss));
`endif
    endtask

    task automatic step(input string tag, input logic fv, input logic fb, input logic [AW-1:0] fa,
                        input logic [AW-1:0] ft, input logic rv, input logic rr, input logic rs,
                        input logic [AW-1:0] ra, input logic [AW-1:0] fba);
        fetch_valid = fv; fetch_is_branch = fb; fetch_addr = fa; fetch_target = ft;
        resolve_valid = rv; resolve_result = rr; resolve_successful = rs;
        resolve_addr = ra; failback_addr = fba;
        @(posedge clk);
        model_edge();
        #1 check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, '0, '0, 0, 0, 0, '0, '0);
    endtask

    initial begin
        model_reset();
        #1 check_all("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        step("fetch_010", 1, 1, 11'h010, 11'h200, 0, 0, 0, '0, '0);
        chk("tp_cold_taken", 16'(predict_taken), 16'h0);
        chk("tp_cold_addr", 16'(predict_addr), 16'h011);

        step("up1_010", 0, 0, '0, '0, 1, 1, 1, 11'h010, '0);
        step("up2_010", 0, 0, '0, '0, 1, 1, 1, 11'h010, '0);
        step("fetch_010_hot", 1, 1, 11'h010, 11'h200, 0, 0, 0, '0, '0);
        chk("tp_hot_taken", 16'(predict_taken), 16'h1);
        chk("tp_hot_addr", 16'(predict_addr), 16'h200);

        step("mispredict_020", 0, 0, '0, '0, 1, 0, 0, 11'h020, 11'h055);
        chk("tp_redirect_valid", 16'(redirect_valid), 16'h1);
        chk("tp_redirect_addr", 16'(redirect_addr), 16'h055);
        chk("tp_flush_c1", 16'(flush), 16'h1);
        step("flush_c2", 1, 1, 11'h010, 11'h300, 1, 0, 0, 11'h010, 11'h0AA);
        chk("tp_redirect_pulse", 16'(redirect_valid), 16'h0);
        chk("tp_flush_c2", 16'(flush), 16'h1);
        chk("tp_redirect_hold", 16'(redirect_addr), 16'h055);
        step("flush_end", 1, 1, 11'h010, 11'h300, 0, 0, 0, '0, '0);
        chk("tp_flush_done", 16'(flush), 16'h0);
        step("fetch_010_after", 1, 1, 11'h010, 11'h200, 0, 0, 0, '0, '0);
        chk("tp_table_untouched", 16'(predict_taken), 16'h1);

        step("fetch_7ff", 1, 0, 11'h7FF, 11'h123, 0, 0, 0, '0, '0);
        chk("tp_wrap", 16'(predict_addr), 16'h000);
        idle("hold");

        for (int i = 0; i < 5; i++) step("down_005", 0, 0, '0, '0, 1, 0, 1, 11'h005, '0);
        for (int i = 0; i < 5; i++) step("up_fetch_005", 1, 1, 11'h005, 11'h0F0, 1, 1, 1, 11'h015, '0);
        step("sat_hi_005", 1, 1, 11'h005, 11'h0F0, 1, 0, 1, 11'h005, '0);
        chk("tp_sat_hi", 16'(predict_taken), 16'h1);

        for (int i = 0; i < 400; i++)
            step("rand", ($urandom % 4) != 0, 1'($urandom), 11'($urandom), 11'($urandom),
                 1'($urandom), 1'($urandom), ($urandom % 6) != 0, 11'($urandom), 11'($urandom));
        repeat (FC + 1) idle("drain");

        step("retrain1", 0, 0, '0, '0, 1, 1, 1, 11'h010, '0);
        step("retrain2", 0, 0, '0, '0, 1, 1, 1, 11'h010, '0);
        step("mp_rst", 1, 1, 11'h010, 11'h200, 1, 0, 0, 11'h033, 11'h444);
        chk("tp_pre_rst_taken", 16'(predict_taken), 16'h1);
        idle("flush_c1_rst");
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1 check_all("rst_mid_flush");
        chk("tp_rst_flush", 16'(flush), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("fetch_010_reinit", 1, 1, 11'h010, 11'h200, 0, 0, 0, '0, '0);
        chk("tp_reinit_taken", 16'(predict_taken), 16'h0);

        for (int i = 0; i < 3; i++) step("hit", 0, 0, '0, '0, 1, 1, 1, 11'(i), '0);
        step("miss", 0, 0, '0, '0, 1, 1, 0, 11'h007, 11'h100);
        repeat (FC + 1) idle("stats_drain");
`ifdef PREDICTOR_STATS_EN
        chk("tp_hits", hit_count, 16'd3);
        chk("tp_miss", miss_count, 16'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
